// File: rtl/gpu_line_pkg.sv
// Shared types and helpers for the scanline compositor: buffer entry layout,
// sequencing states and constant log2 helper.
package gpu_line_pkg;

    localparam int DEF_BPP   = 4;
    localparam int DEF_Z_W   = 2;
    localparam int DEF_PAL_W = 5;
    localparam int DEF_E     = 1 + DEF_Z_W + DEF_PAL_W + DEF_BPP;

    // Entry field offsets, LSB first: index, palette, z, updated flag
    localparam int IDX_LSB = 0;
    localparam int PAL_LSB = DEF_BPP;
    localparam int Z_LSB   = DEF_BPP + DEF_PAL_W;
    localparam int U_BIT   = DEF_E - 1;

    typedef struct packed {
        logic                 updated;
        logic [DEF_Z_W-1:0]   z;
        logic [DEF_PAL_W-1:0] palette;
        logic [DEF_BPP-1:0]   index;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DRAIN
    } state_e;

    function automatic int clog2_c(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic entry_t entry_pack(input logic u, input logic [DEF_Z_W-1:0] z,
                                          input logic [DEF_PAL_W-1:0] pal,
                                          input logic [DEF_BPP-1:0] idx);
        entry_t e;
        e.updated = u;
        e.z       = z;
        e.palette = pal;
        e.index   = idx;
        return e;
    endfunction

    function automatic entry_t entry_unpack(input logic [DEF_E-1:0] bits);
        return entry_t'(bits);
    endfunction

endpackage

// File: rtl/line_compositor_pixel_merge.sv
// Per-pixel transparency and z-priority resolve for one line-buffer entry.
module pixel_merge #(
    parameter int BPP   = 4,
    parameter int Z_W   = 2,
    parameter int PAL_W = 5
) (
    input  logic                       i_en,
    input  logic [BPP-1:0]             i_d,
    input  logic [BPP+PAL_W+Z_W:0]     i_old,
    input  logic [Z_W-1:0]             i_z,
    input  logic [PAL_W-1:0]           i_pal,
    output logic [BPP+PAL_W+Z_W:0]     o_entry
);
    localparam int E = 1 + Z_W + PAL_W + BPP;

    logic           w_u;
    logic [Z_W-1:0] w_zb;
    logic           w_write;

    assign w_u  = i_old[E-1];
    assign w_zb = i_old[BPP+PAL_W +: Z_W];

    // Untouched pixels take anything; touched ones need an opaque, nearer pixel
    assign w_write = i_en && (!w_u || ((i_d != '0) && (i_z > w_zb)));

    assign o_entry = w_write ? {1'b1, i_z, i_pal, i_d} : i_old;

endmodule

// File: rtl/line_compositor.sv
// Streams packed tile words into the line back buffer, realigned by a fine
// pixel offset, with read-modify-write priority merge and right-edge clipping.
module line_compositor
    import gpu_line_pkg::*;
#(
    parameter int PIX_PER_WORD = 4,
    parameter int TILE_PIX     = 8,
    parameter int BPP          = DEF_BPP,
    parameter int Z_W          = DEF_Z_W,
    parameter int PAL_W        = DEF_PAL_W,
    parameter int ADDR_W       = 6,
    parameter int LINE_WORDS   = 40
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        span_start,
    input  logic [ADDR_W-1:0]                           span_base,
    input  logic [clog2_c(PIX_PER_WORD)-1:0]            span_offset,
    input  logic [Z_W-1:0]                              span_z,
    input  logic [PAL_W-1:0]                            span_palette,
    input  logic                                        tile_valid,
    output logic                                        tile_ready,
    input  logic [TILE_PIX*BPP-1:0]                     tile_data,
    input  logic                                        tile_last,
    output logic                                        buf_rd_en,
    output logic [ADDR_W-1:0]                           buf_rd_addr,
    input  logic [PIX_PER_WORD*(1+Z_W+PAL_W+BPP)-1:0]   buf_rd_data,
    output logic                                        buf_wr_en,
    output logic [ADDR_W-1:0]                           buf_wr_addr,
    output logic [PIX_PER_WORD*(1+Z_W+PAL_W+BPP)-1:0]   buf_wr_data,
    output logic                                        busy,
    output logic                                        done
);
    localparam int P     = PIX_PER_WORD;
    localparam int E     = 1 + Z_W + PAL_W + BPP;
    localparam int S_W   = clog2_c(P);
    localparam int SUB_N = TILE_PIX / P;
    localparam int SUB_W = (SUB_N > 1) ? clog2_c(SUB_N) : 1;
    localparam int WB    = P * BPP;

    state_e                 r_state;
    state_e                 w_state_next;
    logic [ADDR_W:0]        r_addr;
    logic [S_W-1:0]         r_s;
    logic [Z_W-1:0]         r_z;
    logic [PAL_W-1:0]       r_pal;
    logic [TILE_PIX*BPP-1:0] r_hold;
    logic                   r_hold_valid;
    logic                   r_hold_last;
    logic                   r_first;
    logic [SUB_W-1:0]       r_sub;
    logic [WB-1:0]          r_carry;

    logic                   r_s1_valid;
    logic                   r_s1_wr;
    logic [ADDR_W-1:0]      r_s1_addr;
    logic [WB-1:0]          r_s1_pix;
    logic [P-1:0]           r_s1_mask;

    logic                   r_s2_valid;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [P*E-1:0]         r_wr_data;

    logic [WB-1:0]          w_sub_word;
    logic                   w_sub_last;
    logic                   w_run_issue;
    logic                   w_flush_issue;
    logic                   w_issue;
    logic                   w_clip;
    logic                   w_tile_acc;
    logic [2*WB-1:0]        w_window;
    logic [WB-1:0]          w_iss_pix;
    logic [P-1:0]           w_iss_mask;
    logic [P*E-1:0]         w_merged;

    assign w_sub_word    = r_hold[int'(r_sub)*WB +: WB];
    assign w_sub_last    = (int'(r_sub) == SUB_N - 1);
    assign w_run_issue   = (r_state == ST_RUN) && r_hold_valid;
    assign w_flush_issue = (r_state == ST_FLUSH) && (r_s != '0);
    assign w_issue       = w_run_issue || w_flush_issue;
    assign w_clip        = (r_addr >= (ADDR_W+1)'(LINE_WORDS));

    assign tile_ready = (r_state == ST_RUN) && (!r_hold_valid || (w_sub_last && !r_hold_last));
    assign w_tile_acc = tile_valid && tile_ready;

    // Previous sub-word supplies the s leading pixels of each output word
    always_comb begin
        w_window   = w_run_issue ? {w_sub_word, r_carry} : {{WB{1'b0}}, r_carry};
        w_iss_pix  = WB'(w_window >> ((P - int'(r_s)) * BPP));
        w_iss_mask = '1;
        for (int p = 0; p < P; p++) begin
            if (w_flush_issue)
                w_iss_mask[p] = (p < int'(r_s));
            else if (r_first)
                w_iss_mask[p] = (p >= int'(r_s));
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (span_start) w_state_next = ST_RUN;
            ST_RUN:   if (w_run_issue && w_sub_last && r_hold_last) w_state_next = ST_FLUSH;
            ST_FLUSH: w_state_next = ST_DRAIN;
            ST_DRAIN: if (!r_s1_valid && !r_s2_valid) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_merge
            pixel_merge #(
                .BPP   (BPP),
                .Z_W   (Z_W),
                .PAL_W (PAL_W)
            ) u_merge (
                .i_en    (r_s1_mask[gi]),
                .i_d     (r_s1_pix[gi*BPP +: BPP]),
                .i_old   (buf_rd_data[gi*E +: E]),
                .i_z     (r_z),
                .i_pal   (r_pal),
                .o_entry (w_merged[gi*E +: E])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_s          <= '0;
            r_z          <= '0;
            r_pal        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_hold_last  <= 1'b0;
            r_first      <= 1'b0;
            r_sub        <= '0;
            r_carry      <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_wr      <= 1'b0;
            r_s1_addr    <= '0;
            r_s1_pix     <= '0;
            r_s1_mask    <= '0;
            r_s2_valid   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && span_start) begin
                r_addr       <= {1'b0, span_base};
                r_s          <= span_offset;
                r_z          <= span_z;
                r_pal        <= span_palette;
                r_carry      <= '0;
                r_first      <= 1'b1;
                r_hold_valid <= 1'b0;
                r_sub        <= '0;
            end
            if (w_issue)
                r_addr <= r_addr + 1'b1;
            if (w_run_issue) begin
                r_carry <= w_sub_word;
                r_first <= 1'b0;
                r_sub   <= w_sub_last ? '0 : SUB_W'(r_sub + 1'b1);
            end
            if (w_tile_acc) begin
                r_hold       <= tile_data;
                r_hold_valid <= 1'b1;
                r_hold_last  <= tile_last;
            end else if (w_run_issue && w_sub_last) begin
                r_hold_valid <= 1'b0;
            end
            // Read stage: clipped slots still travel so completion timing holds
            r_s1_valid <= w_issue;
            r_s1_wr    <= w_issue && !w_clip;
            r_s1_addr  <= r_addr[ADDR_W-1:0];
            r_s1_pix   <= w_iss_pix;
            r_s1_mask  <= w_iss_mask;
            r_s2_valid <= r_s1_valid;
            r_wr_en    <= r_s1_wr;
            r_wr_addr  <= r_s1_addr;
            r_wr_data  <= w_merged;
        end
    end

    assign buf_rd_en   = w_issue && !w_clip;
    assign buf_rd_addr = r_addr[ADDR_W-1:0];
    assign buf_wr_en   = r_wr_en;
    assign buf_wr_addr = r_wr_addr;
    assign buf_wr_data = r_wr_data;
    assign done        = (r_state == ST_DRAIN) && !r_s1_valid && !r_s2_valid;
    assign busy        = (r_state != ST_IDLE) && !done;

endmodule

// File: tb/tb_line_compositor.sv
// Directed bench for line_compositor: buffer model, expected-write scoreboard
// and a decoupled write monitor.
module tb_line_compositor;
    import gpu_line_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        span_start = 1'b0;
    logic [5:0]  span_base = '0;
    logic [1:0]  span_offset = '0;
    logic [1:0]  span_z = '0;
    logic [4:0]  span_palette = '0;
    logic        tile_valid = 1'b0;
    logic        tile_ready;
    logic [31:0] tile_data = '0;
    logic        tile_last = 1'b0;
    logic        buf_rd_en;
    logic [5:0]  buf_rd_addr;
    logic [47:0] buf_rd_data = '0;
    logic        buf_wr_en;
    logic [5:0]  buf_wr_addr;
    logic [47:0] buf_wr_data;
    logic        busy;
    logic        done;

    line_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .span_start   (span_start),
        .span_base    (span_base),
        .span_offset  (span_offset),
        .span_z       (span_z),
        .span_palette (span_palette),
        .tile_valid   (tile_valid),
        .tile_ready   (tile_ready),
        .tile_data    (tile_data),
        .tile_last    (tile_last),
        .buf_rd_en    (buf_rd_en),
        .buf_rd_addr  (buf_rd_addr),
        .buf_rd_data  (buf_rd_data),
        .buf_wr_en    (buf_wr_en),
        .buf_wr_addr  (buf_wr_addr),
        .buf_wr_data  (buf_wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [47:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          acc_cyc_q[$];
    int          wr_cyc_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          illegal = 0;
    logic [47:0] mem [0:63];
    logic        fill_req = 1'b0;
    logic [47:0] fill_word = '0;
    logic [31:0] tile_tab [0:3];

    always @(posedge clk) cyc <= cyc + 1;

    // Line buffer model: one-cycle synchronous read, bulk fill on request
    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 64; i++) mem[i] <= fill_word;
        end else begin
            if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
            if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (buf_wr_en) begin
            wr_t e;
            last_wr_cyc = cyc;
            wr_cyc_q.push_back(cyc);
            $display("write cyc=%0d addr=%0d data=%h", cyc, buf_wr_addr, buf_wr_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {58'd0, buf_wr_addr}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {58'd0, buf_wr_addr}, {58'd0, e.addr});
                chk("wr_data", {16'd0, buf_wr_data}, {16'd0, e.data});
            end
        end
        if ((buf_rd_en && buf_rd_addr >= 6'd40) || (buf_wr_en && buf_wr_addr >= 6'd40))
            illegal++;
    end

    function automatic logic [11:0] pk(input logic u, input logic [1:0] z,
                                       input logic [4:0] pal, input logic [3:0] idx);
        return 12'(entry_pack(u, z, pal, idx));
    endfunction

    function automatic logic [47:0] wd(input logic [11:0] e3, input logic [11:0] e2,
                                       input logic [11:0] e1, input logic [11:0] e0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic push(input logic [5:0] a, input logic [47:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic fill(input logic [47:0] w);
        fill_word = w;
        fill_req  = 1'b1;
        @(negedge clk);
        fill_req  = 1'b0;
    endtask

    task automatic send_tile(input logic [31:0] d, input logic last);
        bit acc;
        int n;
        n = 0;
        tile_valid = 1'b1;
        tile_data  = d;
        tile_last  = last;
        do begin
            acc = tile_ready;
            if (acc) acc_cyc_q.push_back(cyc);
            @(negedge clk);
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("tile_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_span(input logic [5:0] base, input logic [1:0] s, input logic [1:0] z,
                            input logic [4:0] pal, input int ntiles, input int done_lag,
                            input string nm);
        int n;
        span_base    = base;
        span_offset  = s;
        span_z       = z;
        span_palette = pal;
        span_start   = 1'b1;
        @(negedge clk);
        span_start = 1'b0;
        chk({nm, "_busy"}, {63'd0, busy}, 64'd1);
        for (int k = 0; k < ntiles; k++) send_tile(tile_tab[k], k == ntiles - 1);
        tile_valid = 1'b0;
        tile_last  = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk({nm, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({nm, "_done_cycle"}, 64'(cyc), 64'(last_wr_cyc + done_lag));
            chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
        end
        $display("span %s finished cyc=%0d", nm, cyc);
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] f;
        logic [11:0] e;
        int n;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", {59'd0, tile_ready, buf_rd_en, buf_wr_en, busy, done}, 64'd0);
        chk("reset_wr_data", {16'd0, buf_wr_data}, 64'd0);

        // s=0: two aligned words, no flush
        fill('0);
        tile_tab[0] = 32'h87654321;
        push(6'd2, wd(pk(1,1,3,4), pk(1,1,3,3), pk(1,1,3,2), pk(1,1,3,1)));
        push(6'd3, wd(pk(1,1,3,8), pk(1,1,3,7), pk(1,1,3,6), pk(1,1,3,5)));
        run_span(6'd2, 2'd0, 2'd1, 5'd3, 1, 1, "s0");

        // s=1: masked leading pixel and one flush word
        fill('0);
        push(6'd0, wd(pk(1,1,3,3), pk(1,1,3,2), pk(1,1,3,1), 12'd0));
        push(6'd1, wd(pk(1,1,3,7), pk(1,1,3,6), pk(1,1,3,5), pk(1,1,3,4)));
        push(6'd2, wd(12'd0, 12'd0, 12'd0, pk(1,1,3,8)));
        run_span(6'd0, 2'd1, 2'd1, 5'd3, 1, 1, "s1");

        // s=2 across two tiles: carry crosses the tile boundary
        fill('0);
        tile_tab[1] = 32'hFEDCBA98;
        push(6'd20, wd(pk(1,2,7,2), pk(1,2,7,1), 12'd0, 12'd0));
        push(6'd21, wd(pk(1,2,7,6), pk(1,2,7,5), pk(1,2,7,4), pk(1,2,7,3)));
        push(6'd22, wd(pk(1,2,7,9), pk(1,2,7,8), pk(1,2,7,8), pk(1,2,7,7)));
        push(6'd23, wd(pk(1,2,7,13), pk(1,2,7,12), pk(1,2,7,11), pk(1,2,7,10)));
        push(6'd24, wd(12'd0, 12'd0, pk(1,2,7,15), pk(1,2,7,14)));
        run_span(6'd20, 2'd2, 2'd2, 5'd7, 2, 1, "s2");

        // Priority against an already-drawn layer at z=2, index 9
        f = pk(1,2,0,9);
        fill(wd(f, f, f, f));
        push(6'd5, wd(f, f, f, f));
        push(6'd6, wd(f, f, f, f));
        run_span(6'd5, 2'd0, 2'd1, 5'd4, 1, 1, "prio_far");
        push(6'd10, wd(f, f, f, f));
        push(6'd11, wd(f, f, f, f));
        run_span(6'd10, 2'd0, 2'd2, 5'd4, 1, 1, "prio_equal");
        tile_tab[0] = 32'h00650021;
        push(6'd5, wd(f, f, pk(1,3,4,2), pk(1,3,4,1)));
        push(6'd6, wd(f, f, pk(1,3,4,6), pk(1,3,4,5)));
        run_span(6'd5, 2'd0, 2'd3, 5'd4, 1, 1, "prio_near");
        tile_tab[0] = 32'h00000000;
        push(6'd8, wd(f, f, f, f));
        push(6'd9, wd(f, f, f, f));
        run_span(6'd8, 2'd0, 2'd3, 5'd4, 1, 1, "prio_clear");

        // Throughput: four tiles held valid back to back
        fill('0);
        for (int k = 0; k < 4; k++) begin
            tile_tab[k] = 32'h11111111 * (k + 1);
            e = pk(1, 1, 3, 4'(k + 1));
            push(6'(10 + 2 * k), wd(e, e, e, e));
            push(6'(11 + 2 * k), wd(e, e, e, e));
        end
        acc_cyc_q.delete();
        wr_cyc_q.delete();
        run_span(6'd10, 2'd0, 2'd1, 5'd3, 4, 1, "thru");
        chk("thru_accepts", 64'(acc_cyc_q.size()), 64'd4);
        for (int k = 1; k < acc_cyc_q.size(); k++)
            chk("thru_ready_spacing", 64'(acc_cyc_q[k] - acc_cyc_q[k-1]), 64'd2);
        chk("thru_writes", 64'(wr_cyc_q.size()), 64'd8);
        if (wr_cyc_q.size() == 8)
            chk("thru_write_span", 64'(wr_cyc_q[7] - wr_cyc_q[0]), 64'd7);

        // Right-edge clip: second slot lands on addr 40
        fill('0);
        tile_tab[0] = 32'h87654321;
        illegal = 0;
        push(6'd39, wd(pk(1,1,3,4), pk(1,1,3,3), pk(1,1,3,2), pk(1,1,3,1)));
        run_span(6'd39, 2'd0, 2'd1, 5'd3, 1, 2, "clip");
        chk("clip_no_access_40", 64'(illegal), 64'd0);

        // Reset one cycle after the first read: nothing may be written
        span_base    = 6'd0;
        span_offset  = 2'd0;
        span_z       = 2'd1;
        span_palette = 5'd3;
        span_start   = 1'b1;
        @(negedge clk);
        span_start = 1'b0;
        tile_valid = 1'b1;
        tile_data  = 32'h87654321;
        tile_last  = 1'b1;
        @(negedge clk);
        tile_valid = 1'b0;
        tile_last  = 1'b0;
        n = 0;
        while (!buf_rd_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_first_read", {63'd0, buf_rd_en}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("rst_quiet", {59'd0, tile_ready, buf_rd_en, buf_wr_en, busy, done}, 64'd0);
            @(negedge clk);
        end

        // Normal span after the mid-span reset
        fill('0);
        push(6'd2, wd(pk(1,1,3,4), pk(1,1,3,3), pk(1,1,3,2), pk(1,1,3,1)));
        push(6'd3, wd(pk(1,1,3,8), pk(1,1,3,7), pk(1,1,3,6), pk(1,1,3,5)));
        run_span(6'd2, 2'd0, 2'd1, 5'd3, 1, 1, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_compositor.md
Name: line_compositor

Overview:
- Streaming successor to the per-word pixel merge stage. Accepts one sprite or background span per scanline as a sequence of packed tile words, realigns them by a fine pixel offset, and read-modify-writes the current-line back buffer with per-pixel transparency and z-priority resolution.
- Sits between the tile fetch unit (upstream, valid/ready) and the dual-port line back buffer (downstream, 1-cycle synchronous read).
- Owns span sequencing, the pixel carry between words, the trailing flush word and right-edge clipping internally.

Parameters:
- PIX_PER_WORD, 4, pixels per line-buffer word (P); power of two.
- TILE_PIX, 8, pixels per input tile word (T); a multiple of P.
- BPP, 4, bits per colour index; index 0 is transparent.
- Z_W, 2, priority bits; a larger value is nearer.
- PAL_W, 5, palette select bits.
- ADDR_W, 6, line-buffer address width.
- LINE_WORDS, 40, valid buffer words per line; addresses >= LINE_WORDS are clipped.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- span_start  in  1  one-cycle command; accepted only while idle.
- span_base  in  ADDR_W  buffer word address of the first output word.
- span_offset  in  log2(P)  fine offset s; stream pixel 0 lands at pixel s of word span_base.
- span_z  in  Z_W  span priority.
- span_palette  in  PAL_W  span palette.
- tile_valid  in  1  tile word valid.
- tile_ready  out  1  tile word accepted when valid && ready.
- tile_data  in  T*BPP  pixel 0 in LSBs.
- tile_last  in  1  marks the final tile word of the span.
- buf_rd_en  out  1  buffer read strobe.
- buf_rd_addr  out  ADDR_W  buffer read address.
- buf_rd_data  in  P*E  read data, valid the cycle after buf_rd_en.
- buf_wr_en  out  1  buffer write strobe.
- buf_wr_addr  out  ADDR_W  buffer write address.
- buf_wr_data  out  P*E  write data.
- busy  out  1  high from span acceptance until done.
- done  out  1  one-cycle pulse when the span is complete.

Behaviour:
- Buffer entry E = 1+Z_W+PAL_W+BPP bits, packed {updated, z, palette, index}. Pixel p of a word is at bits [p*E +: E].
- States:
  - IDLE: busy=0, tile_ready=0. span_start latches base, s, z, palette, sets addr=base, clears carry, goes to RUN. span_start is ignored outside IDLE.
  - RUN: holds one tile in a holding register and emits T/P output words from it, one per cycle. tile_ready=1 when the holding register is empty or its last sub-word issues this cycle, giving 1 word/cycle sustained throughput. An empty register is a bubble; nothing is issued.
  - FLUSH: entered after the last sub-word of the tile_last tile. If s!=0, issues one extra word holding the s carried pixels. If s==0, no flush word is issued.
  - DRAIN: waits for in-flight writes to retire, then pulses done, returns to IDLE.
- Output word k (addr = base+k): pixel p takes stream pixel k*P+p-s.
  - Positions with a negative stream index (first word, p<s) are masked and never written.
  - In the flush word, positions p>=s are masked.
- Per unmasked pixel, with d = new index and (u, zb) from the buffer: write iff !u || (d!=0 && span_z > zb). A written pixel becomes {1, span_z, span_palette, d}. Any other pixel, and every masked pixel, is written back with its read value unchanged.
- Pipeline: read issued cycle t, data returns t+1, merge is registered, buf_wr_en at t+2. Addresses strictly increase within a span, so no read-after-write hazard exists and no forwarding is used.
- Clipping: a word with addr >= LINE_WORDS suppresses both read and write, but still consumes its sub-word slot. addr counts in ADDR_W+1 bits, so it never wraps.
- done asserts the cycle after the final buf_wr_en, or after the final clipped slot if the last write is suppressed. busy drops with done.
- Reset values: state=IDLE; tile_ready, buf_rd_en, buf_wr_en, busy, done = 0; addresses, buf_wr_data, carry, holding register = 0.
- Reset mid-span: takes effect on the next edge. No further buffer read or write is issued, and in-flight pipeline stages are discarded.

Decomposition:
- Package gpu_line_pkg:
  - entry field widths and offsets, and entry pack/unpack functions;
  - the state enum;
  - log2 constant helpers.
- Sub-module pixel_merge: purely combinational per-pixel resolve (mask, d, u, zb, span z/palette -> entry). Instantiated P times in the write stage.

Test Plan:
- s=0, base=2, z=1, pal=3, one tile 0x87654321 (tile_last), buffer cleared -> exactly 2 writes: addr2 indices {1,2,3,4}, addr3 {5,6,7,8}, all u=1, z=1, pal=3. No flush word. done 1 cycle after the addr3 write.
- s=1, base=0, same tile, buffer cleared -> addr0 p0 unchanged, p1..3 = {1,2,3}; addr1 = {4,5,6,7}; flush addr2 p0=8, p1..3 unchanged. 3 writes total.
- Priority: buffer word all {1, z=2, pal=0, idx=9}; span z=1 with nonzero indices -> unchanged. Span z=3 -> overwritten. Span z=3 with index 0 -> unchanged.
- Throughput: 4 back-to-back tiles with tile_valid held high -> tile_ready pulses every 2 cycles, 8 consecutive buf_wr_en cycles with no bubble.
- Clipping: LINE_WORDS=40, base=39, s=0, one tile -> one write at addr 39, no access at addr 40, done still pulses.
- Reset asserted 1 cycle after the first buf_rd_en -> no buf_wr_en thereafter, all outputs 0. A new span_start then completes normally.
